// File: rtl/rc4_msg_buffer_if.sv
// Bundle of the UART-side, decrypt-core-side and status signals of rc4_msg_buffer.
// The slave modport is the buffer itself; the master modport is whatever surrounds it.
interface rc4_msg_buffer_if #(
  parameter int BYTES_LEN = 16
);
  logic [7:0]             rx_data;
  logic                   rx_valid;
  logic [BYTES_LEN*8-1:0] dec_bytes_in;
  logic                   dec_enable;
  logic [BYTES_LEN*8-1:0] dec_bytes_out;
  logic                   dec_done;
  logic [7:0]             tx_data;
  logic                   tx_start;
  logic                   tx_busy;
  logic                   busy;
  logic                   overrun;
  logic                   msg_done;

  modport master (
    output rx_data, rx_valid, dec_bytes_out, dec_done, tx_busy,
    input  dec_bytes_in, dec_enable, tx_data, tx_start, busy, overrun, msg_done
  );

  modport slave (
    input  rx_data, rx_valid, dec_bytes_out, dec_done, tx_busy,
    output dec_bytes_in, dec_enable, tx_data, tx_start, busy, overrun, msg_done
  );
endinterface

// File: rtl/rc4_msg_buffer.sv
// Frames BYTES_LEN UART bytes into one message for the RC4 decrypt core, then
// streams the decrypted result back to the UART transmitter byte by byte.
module rc4_msg_buffer #(
  parameter int BYTES_LEN = 16
) (
  input logic            clk,
  input logic            reset,
  rc4_msg_buffer_if.slave bus
);

  localparam int             IW       = $clog2(BYTES_LEN + 1);
  localparam logic [IW-1:0]  LAST_IDX = IW'(BYTES_LEN - 1);
  localparam int             MW       = BYTES_LEN * 8;

  typedef enum logic [2:0] {
    S_RX       = 3'd0,
    S_DECRYPT  = 3'd1,
    S_TX_START = 3'd2,
    S_TX_ACK   = 3'd3,
    S_TX_WAIT  = 3'd4
  } state_t;

  state_t         state_r;
  state_t         next_state_s;
  logic [IW-1:0]  idx_r;
  logic [IW-1:0]  slot_s;
  logic [MW-1:0]  dec_bytes_in_r;
  logic [MW-1:0]  result_r;
  logic           dec_enable_r;
  logic [7:0]     tx_data_r;
  logic           tx_start_r;
  logic           busy_r;
  logic           overrun_r;
  logic           msg_done_r;

  logic           rx_take_s;
  logic           rx_last_s;
  logic           capture_s;
  logic           send_s;
  logic           advance_s;
  logic           finish_s;

  // Next-state logic and one-cycle action strobes for the datapath.
  always_comb begin
    next_state_s = state_r;
    slot_s       = LAST_IDX - idx_r;
    rx_take_s    = 1'b0;
    rx_last_s    = 1'b0;
    capture_s    = 1'b0;
    send_s       = 1'b0;
    advance_s    = 1'b0;
    finish_s     = 1'b0;
    case (state_r)
      S_RX: begin
        if (bus.rx_valid) begin
          rx_take_s = 1'b1;
          if (idx_r == LAST_IDX) begin
            rx_last_s    = 1'b1;
            next_state_s = S_DECRYPT;
          end else begin
            next_state_s = S_RX;
          end
        end else begin
          next_state_s = S_RX;
        end
      end
      S_DECRYPT: begin
        if (bus.dec_done) begin
          capture_s    = 1'b1;
          next_state_s = S_TX_START;
        end else begin
          next_state_s = S_DECRYPT;
        end
      end
      S_TX_START: begin
        if (!bus.tx_busy) begin
          send_s       = 1'b1;
          next_state_s = S_TX_ACK;
        end else begin
          next_state_s = S_TX_START;
        end
      end
      S_TX_ACK: begin
        if (bus.tx_busy) begin
          next_state_s = S_TX_WAIT;
        end else begin
          next_state_s = S_TX_ACK;
        end
      end
      S_TX_WAIT: begin
        if (!bus.tx_busy) begin
          if (idx_r == LAST_IDX) begin
            finish_s     = 1'b1;
            next_state_s = S_RX;
          end else begin
            advance_s    = 1'b1;
            next_state_s = S_TX_START;
          end
        end else begin
          next_state_s = S_TX_WAIT;
        end
      end
      default: begin
        next_state_s = S_RX;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= S_RX;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Byte index: wrap-back to 0 is explicit at message and stream boundaries.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_r <= '0;
    end else if (rx_take_s) begin
      idx_r <= rx_last_s ? '0 : idx_r + IW'(1);
    end else if (capture_s || finish_s) begin
      idx_r <= '0;
    end else if (advance_s) begin
      idx_r <= idx_r + IW'(1);
    end else begin
      idx_r <= idx_r;
    end
  end

  // Receive packing (first byte lands in the top slot) and result capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dec_bytes_in_r <= '0;
      result_r       <= '0;
      dec_enable_r   <= 1'b0;
    end else begin
      if (rx_take_s) begin
        dec_bytes_in_r[{slot_s, 3'b000} +: 8] <= bus.rx_data;
      end
      if (rx_last_s) begin
        dec_enable_r <= 1'b1;
      end else if (capture_s) begin
        dec_enable_r <= 1'b0;
        result_r     <= bus.dec_bytes_out;
      end
    end
  end

  // Transmit request, status flags and the end-of-message pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_data_r  <= 8'h00;
      tx_start_r <= 1'b0;
      busy_r     <= 1'b0;
      overrun_r  <= 1'b0;
      msg_done_r <= 1'b0;
    end else begin
      tx_start_r <= send_s;
      msg_done_r <= finish_s;
      busy_r     <= (next_state_s != S_RX);
      if (send_s) begin
        tx_data_r <= result_r[{slot_s, 3'b000} +: 8];
      end
      // A byte arriving while we are not listening is dropped, but remembered.
      if (bus.rx_valid && (state_r != S_RX)) begin
        overrun_r <= 1'b1;
      end
    end
  end

  assign bus.dec_bytes_in = dec_bytes_in_r;
  assign bus.dec_enable   = dec_enable_r;
  assign bus.tx_data      = tx_data_r;
  assign bus.tx_start     = tx_start_r;
  assign bus.busy         = busy_r;
  assign bus.overrun      = overrun_r;
  assign bus.msg_done     = msg_done_r;

endmodule

// File: doc/rc4_msg_buffer.md
# rc4_msg_buffer

Message framing stage between the UART receiver/transmitter and the RC4 decrypt core. Packs BYTES_LEN received UART bytes into one message vector, starts the decrypt core, and captures its result. It then streams the decrypted bytes back out to the UART transmitter one byte at a time. Runs continuously: after the last byte is transmitted it re-arms for the next message.

## Interface
- BYTES_LEN, 16, message length in bytes; must match the decrypt core's BYTES_LEN; legal range 1..64.
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- rx_data  in  8  byte from the UART receiver; valid only when rx_valid=1.
- rx_valid  in  1  one-cycle strobe per received byte.
- dec_bytes_in  out  BYTES_LEN*8  message to the decrypt core; the first received byte is in bits [BYTES_LEN*8-1 -: 8].
- dec_enable  out  1  start level to the decrypt core; held high until dec_done is seen.
- dec_bytes_out  in  BYTES_LEN*8  decrypt result; valid in the cycle dec_done=1.
- dec_done  in  1  one-cycle completion pulse from the decrypt core.
- tx_data  out  8  byte to the UART transmitter.
- tx_start  out  1  one-cycle send request to the UART transmitter.
- tx_busy  in  1  transmitter busy; rises after tx_start and stays high for the whole frame.
- busy  out  1  high in every state except S_RX.
- overrun  out  1  sticky; set when rx_valid arrives outside S_RX; cleared only by reset.
- msg_done  out  1  one-cycle pulse after the last output byte completes.

## Operation
- States: S_RX, S_DECRYPT, S_TX_START, S_TX_ACK, S_TX_WAIT.
- Reset values: state S_RX; byte index 0; dec_bytes_in 0; dec_enable 0; tx_data 0; tx_start 0; overrun 0; msg_done 0; internal result register 0.
- S_RX: each rx_valid writes rx_data into dec_bytes_in slot (BYTES_LEN-1-idx) and increments idx.
  - On the rx_valid with idx==BYTES_LEN-1: idx←0, dec_enable←1, state→S_DECRYPT.
  - Bytes are packed most significant first, so byte order is preserved through the decrypt core.
- S_DECRYPT: dec_enable stays 1 and dec_bytes_in is frozen.
  - On dec_done=1: result←dec_bytes_out, dec_enable←0, idx←0, state→S_TX_START.
  - dec_done seen in any other state is ignored.
- S_TX_START: if tx_busy=0, tx_data←result byte (BYTES_LEN-1-idx), tx_start←1 for one cycle, state→S_TX_ACK. Otherwise stay in S_TX_START.
- S_TX_ACK: wait for tx_busy=1, then →S_TX_WAIT.
- S_TX_WAIT: wait for tx_busy=0.
  - If idx==BYTES_LEN-1: idx←0, msg_done←1, state→S_RX.
  - Otherwise: idx←idx+1, state→S_TX_START.
- rx_valid in any state other than S_RX: the byte is discarded and overrun←1; the datapath is unaffected.
- idx is a $clog2(BYTES_LEN+1)-bit counter. It never exceeds BYTES_LEN-1, and wrap-back to 0 is explicit.
- BYTES_LEN=1: a single rx_valid goes straight to S_DECRYPT; a single transmit returns to S_RX.
- Reset asserted mid-operation (any state) returns all outputs to their reset values immediately.
  - dec_enable falling lets the decrypt core return to its idle state.
  - A partially received message is discarded.

## Timing
- All outputs are registered; there are no combinational input→output paths.
- Last rx_valid sampled at edge N: dec_enable=1 and the full dec_bytes_in are visible after edge N.
- dec_done sampled at edge M: dec_enable=0 after edge M. At the earliest, tx_start=1 after edge M+1 (S_TX_START with tx_busy=0).
- dec_enable is low for at least 2×BYTES_LEN+2 cycles between messages, which covers the decrypt core's enable-low return to idle.
- tx_start is never high in two consecutive cycles, and is never asserted while tx_busy=1.
- msg_done is high for exactly the one cycle after the edge that sampled the final tx_busy fall. The next rx_valid is accepted in that same cycle.

## Test plan
- BYTES_LEN=4, send 0x11,0x22,0x33,0x44 -> dec_bytes_in=0x11223344; dec_enable rises the cycle after the 4th strobe; busy=1.
- Stub decrypt model returns input^0xFFFFFFFF, with dec_done 20 cycles after enable -> tx bytes 0xEE,0xDD,0xCC,0xBB in order; dec_enable drops the cycle after dec_done; one msg_done pulse.
- Stub UART transmitter with 10-cycle busy, tx_busy held high 5 cycles at S_TX_START entry -> tx_start is delayed until tx_busy=0; exactly 4 tx_start pulses in total, none overlapping busy.
- Strobe rx_valid with 0x55 during S_DECRYPT -> overrun=1 and stays 1; the output stream is unchanged; the next message is still received correctly.
- Reset asserted after 2 of 4 bytes, then 4 new bytes 0xA0..0xA3 -> dec_bytes_in=0xA0A1A2A3; no remnant of the old bytes.
- Reset during S_TX_WAIT -> dec_enable=0, tx_start=0, state S_RX; a back-to-back second message completes normally.
